mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store sequencer between the core's data port and the word-wide data RAM.
//  It accepts one byte, halfword or word request per handshake, and generates
//  word-aligned RAM addresses, per-lane write strobes and shifted write data.
//  It aligns and sign- or zero-extends read data.
//  An access that crosses a word boundary becomes two RAM beats.
//  It sits directly upstream of the RAM: mem_* ports connect to its r/w/in/addr/out.
// PARAMETERS
//  MISALIGN_EN  1  1: split word-crossing accesses into two beats; 0: reject them with err
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  rst          in   1   asynchronous, active-high reset
//  req_valid    in   1   core request valid
//  req_ready    out  1   1 only in IDLE; a request is accepted when req_valid&&req_ready at posedge
//  req_we       in   1   1=store, 0=load
//  req_size     in   2   0=byte, 1=half, 2/3=word
//  req_unsigned in   1   loads only: 1=zero-extend, 0=sign-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-justified
//  done         out  1   one-cycle completion pulse
//  err          out  1   with done: misaligned access rejected (MISALIGN_EN=0)
//  rdata        out  32  extended load data; valid with done and held until the next done
//  mem_r        out  1   RAM read enable
//  mem_w        out  4   RAM byte-lane write strobes; RAM writes them on negedge
//  mem_in       out  32  RAM write data, lane-positioned
//  mem_addr     out  32  RAM byte address, bits[1:0] always 0
//  mem_out      in   32  RAM read data, combinational from mem_addr
// BEHAVIOUR
//  Reset (async): state=IDLE, req_ready=1 once reset is released; done, err, mem_r, mem_w,
//   mem_in, mem_addr and rdata all 0. Reset mid-access abandons the access.
//   A RAM write whose strobes were deasserted before negedge does not occur.
//  All mem_* and response outputs are registered.
//  States: IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE.
//  IDLE: on accept, latch the request.
//   n = 1/2/4 bytes; o = addr[1:0]; m = (1<<n)-1.
//   cross = (o+n > 4). For size 3, use n=4.
//   If cross && !MISALIGN_EN: go to RESP with err=1, no RAM access, rdata=0.
//   Otherwise go to ACC0.
//  ACC0 (one cycle):
//   mem_addr = {addr[31:2],2'b0}.
//   Store: mem_w = (m<<o)[3:0]; mem_in = wdata<<(8*o).
//   Load: mem_r = 1; capture mem_out>>(8*o) into the low bytes at the closing posedge.
//   Next state: ACC1 if cross, else RESP.
//  ACC1 (one cycle):
//   mem_addr = {addr[31:2],2'b0}+4, which wraps mod 2^32 (0xFFFFFFFC+4 -> 0x0).
//   Store: mem_w = m>>(4-o); mem_in = wdata>>(8*(4-o)).
//   Load: mem_r = 1; capture mem_out<<(8*(4-o)) into the upper bytes.
//  RESP: done=1 for exactly this cycle, req_ready=0.
//   Load result: byte uses bit 7, half uses bit 15 as the extension bit,
//   or zero-extends when req_unsigned=1. Word is unmodified.
//   Store result: rdata unchanged.
//  Latency (accept edge to done): aligned = 2 cycles; crossing = 3 cycles; rejected = 1 cycle.
//  mem_w and mem_r are 0 in IDLE and RESP. A load never asserts mem_w.
//   A store never asserts mem_r.
//  req_valid while req_ready=0: ignored, not queued. The core must hold it until accepted.
//  req_* inputs are sampled only at the accept edge. Later changes do not affect the access.
// TESTING
//  1 Reset mid-store in ACC0 -> mem_w=0 and req_ready=1 immediately; the target word is
//    unchanged; done is never pulsed.
//  2 SW 0xDEADBEEF @0x10, then LW @0x10 -> store mem_w=4'hF;
//    load done 2 cycles after accept with rdata=0xDEADBEEF.
//  3 SB 0x80 @0x13, then LB and LBU @0x13 -> mem_w=4'b1000, mem_in[31:24]=0x80;
//    rdata=0xFFFFFF80, then 0x00000080.
//  4 SH 0xA1B2 @0x17 (MISALIGN_EN=1) -> ACC0 @0x14 mem_w=4'b1000 byte 0xB2;
//    ACC1 @0x18 mem_w=4'b0001 byte 0xA1.
//    LH @0x17 -> rdata=0xFFFFA1B2, done 3 cycles after accept.
//  5 LW @0xFFFFFFFE -> beats at 0xFFFFFFFC then 0x00000000;
//    rdata = {mem[0][15:0], mem[last][31:16]}.
//  6 MISALIGN_EN=0, LW @0x21 -> no mem_r/mem_w; the next cycle has done=1, err=1, rdata=0.
//    req_valid pulsed while busy -> no second done.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the core data port and a word-wide RAM.
// Handles byte/half/word accesses, splitting word-crossing ones into two beats.
module mem_access_unit #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_r,
  output logic [3:0]  mem_w,
  output logic [31:0] mem_in,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;

  state_t      state_r, state_s;
  logic        we_r, uns_r, ready_r, done_r, err_r, mem_r_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r, lo_r, rdata_r, mem_in_r, mem_addr_r;
  logic [3:0]  mem_w_r;

  logic        sel_we_s, cross_s, lat_s, done_s, err_s, mem_r_s;
  logic [1:0]  sel_size_s, o_s;
  logic [31:0] sel_addr_s, sel_wdata_s, base_s, lo_s, rdata_s, mem_in_s, mem_addr_s;
  logic [3:0]  m_s, mem_w_s;
  logic [2:0]  n_s;
  logic [4:0]  sh_lo_s, sh_hi_s;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] r;
    case (size)
      2'd0:    r = 3'd1;
      2'd1:    r = 3'd2;
      default: r = 3'd4;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] r;
    case (size)
      2'd0:    r = 4'b0001;
      2'd1:    r = 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] size,
                                              input logic uns);
    logic [31:0] r;
    case (size)
      2'd0:    r = uns ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'd1:    r = uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Beat geometry comes from the live request while idle, else from the latched one.
  always_comb begin
    if (state_r == IDLE) begin
      sel_we_s    = req_we;
      sel_size_s  = req_size;
      sel_addr_s  = req_addr;
      sel_wdata_s = req_wdata;
    end else begin
      sel_we_s    = we_r;
      sel_size_s  = size_r;
      sel_addr_s  = addr_r;
      sel_wdata_s = wdata_r;
    end
    n_s     = size_bytes(sel_size_s);
    m_s     = size_mask(sel_size_s);
    o_s     = sel_addr_s[1:0];
    cross_s = ({1'b0, o_s} + n_s) > 3'd4;
    base_s  = {sel_addr_s[31:2], 2'b00};
    sh_lo_s = {o_s, 3'b000};
    sh_hi_s = {2'd0 - o_s, 3'b000};
  end

  // Next state plus the values every registered output takes in that state.
  always_comb begin
    state_s    = state_r;
    lat_s      = 1'b0;
    done_s     = 1'b0;
    err_s      = 1'b0;
    mem_r_s    = 1'b0;
    mem_w_s    = 4'b0000;
    mem_in_s   = mem_in_r;
    mem_addr_s = mem_addr_r;
    rdata_s    = rdata_r;
    lo_s       = lo_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          lat_s = 1'b1;
          if (cross_s && !MISALIGN_EN) begin
            state_s = RESP;
            done_s  = 1'b1;
            err_s   = 1'b1;
            rdata_s = 32'd0;
          end else begin
            state_s    = ACC0;
            mem_addr_s = base_s;
            if (sel_we_s) begin
              mem_w_s  = m_s << o_s;
              mem_in_s = sel_wdata_s << sh_lo_s;
            end else begin
              mem_r_s = 1'b1;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACC0: begin
        if (!we_r) begin
          lo_s = mem_out >> sh_lo_s;
        end else begin
          lo_s = lo_r;
        end
        if (cross_s) begin
          state_s    = ACC1;
          mem_addr_s = base_s + 32'd4;
          if (we_r) begin
            mem_w_s  = m_s >> (3'd4 - {1'b0, o_s});
            mem_in_s = wdata_r >> sh_hi_s;
          end else begin
            mem_r_s = 1'b1;
          end
        end else begin
          state_s = RESP;
          done_s  = 1'b1;
          if (!we_r) begin
            rdata_s = extend_load(mem_out >> sh_lo_s, size_r, uns_r);
          end else begin
            rdata_s = rdata_r;
          end
        end
      end
      ACC1: begin
        state_s = RESP;
        done_s  = 1'b1;
        // Upper beat supplies the bytes that spilled past the first word.
        if (!we_r) begin
          rdata_s = extend_load(lo_r | (mem_out << sh_hi_s), size_r, uns_r);
        end else begin
          rdata_s = rdata_r;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latched request and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      rdata_r    <= 32'd0;
      mem_r_r    <= 1'b0;
      mem_w_r    <= 4'b0000;
      mem_in_r   <= 32'd0;
      mem_addr_r <= 32'd0;
      lo_r       <= 32'd0;
      we_r       <= 1'b0;
      uns_r      <= 1'b0;
      size_r     <= 2'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
    end else begin
      state_r    <= state_s;
      ready_r    <= (state_s == IDLE);
      done_r     <= done_s;
      err_r      <= err_s;
      rdata_r    <= rdata_s;
      mem_r_r    <= mem_r_s;
      mem_w_r    <= mem_w_s;
      mem_in_r   <= mem_in_s;
      mem_addr_r <= mem_addr_s;
      lo_r       <= lo_s;
      if (lat_s) begin
        we_r    <= req_we;
        uns_r   <= req_unsigned;
        size_r  <= req_size;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
    end
  end

  assign req_ready = ready_r;
  assign done      = done_r;
  assign err       = err_r;
  assign rdata     = rdata_r;
  assign mem_r     = mem_r_r;
  assign mem_w     = mem_w_r;
  assign mem_in    = mem_in_r;
  assign mem_addr  = mem_addr_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-level reference memory, a word RAM
// that writes on negedge, and a second instance with misaligned accesses rejected.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_unsigned, done, err, mem_r;
  logic [1:0]  req_size;
  logic [3:0]  mem_w;
  logic [31:0] req_addr, req_wdata, rdata, mem_in, mem_addr, mem_out;

  logic        b_req_valid, b_req_ready, b_done, b_err, b_mem_r;
  logic [3:0]  b_mem_w;
  logic [31:0] b_req_addr, b_rdata, b_mem_in, b_mem_addr, b_mem_out;

  mem_access_unit #(.MISALIGN_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .err(err), .rdata(rdata), .mem_r(mem_r),
    .mem_w(mem_w), .mem_in(mem_in), .mem_addr(mem_addr), .mem_out(mem_out));

  mem_access_unit #(.MISALIGN_EN(1'b0)) u_rej (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(1'b0),
    .req_size(2'd2), .req_unsigned(1'b0), .req_addr(b_req_addr), .req_wdata(32'd0),
    .done(b_done), .err(b_err), .rdata(b_rdata), .mem_r(b_mem_r), .mem_w(b_mem_w),
    .mem_in(b_mem_in), .mem_addr(b_mem_addr), .mem_out(b_mem_out));

  assign b_mem_out = 32'h5A5A5A5A;

  // Word RAM: low window 0x00-0x3F and high window 0xFFFFFFC0-0xFFFFFFFF
  logic [31:0] ram [32];
  logic [31:0] init_img [32];
  bit          ram_loaded = 1'b0;
  assign mem_out = ram[{mem_addr[31], mem_addr[5:2]}];

  always @(negedge clk) begin
    if (!ram_loaded) begin
      ram        <= init_img;
      ram_loaded <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++)
        if (mem_w[i]) ram[{mem_addr[31], mem_addr[5:2]}][8*i +: 8] <= mem_in[8*i +: 8];
    end
  end

  // Reference model: a byte-addressed memory and the last completed load value
  logic [7:0]  mb [logic [31:0]];
  logic [31:0] last_rdata = 32'd0;
  logic        cur_we = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    longint      t_acc;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  int n_pass = 0;
  int n_checks = 0;
  int b_done_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, expv);
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_access(input logic we, input logic [1:0] size,
      input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    int n = nbytes(size);
    logic [31:0] v = 32'd0;
    if (we) begin
      for (int i = 0; i < n; i++) mb[addr + 32'(i)] = wdata[8*i +: 8];
      return last_rdata;
    end
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[addr + 32'(i)];
    if (!uns && n < 4 && v[8*n-1])
      for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
    last_rdata = v;
    return v;
  endfunction

  // Issue one request at a negedge; returns 1 time unit after the accept edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit track);
    int guard = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      $display("FAIL ready_timeout: got 0 expected 1");
      $fatal(1, "request never accepted");
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    cur_we = we;
    @(posedge clk);
    if (track) begin
      e.rdata = ref_access(we, size, uns, addr, wdata);
      e.err   = 1'b0;
      e.t_acc = longint'($time);
      e.lat   = ((int'(addr[1:0]) + nbytes(size)) > 4) ? 3 : 2;
      sbq.push_back(e);
    end
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Response monitor and bus-protocol checks, sampled on the falling edge
  always @(negedge clk) begin : mon
    exp_t e;
    int lat;
    if (!rst) begin
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sbq.pop_front();
          lat = int'((longint'($time) - e.t_acc - 64'd5) / 64'd10) + 1;
          check("rdata", rdata, e.rdata);
          check("err", 32'(err), 32'(e.err));
          check("latency", 32'(lat), 32'(e.lat));
        end
      end
      if (mem_r || mem_w != 4'd0) begin
        check("addr_align", 32'(mem_addr[1:0]), 32'd0);
        check("lane_kind", 32'(cur_we ? mem_r : (mem_w != 4'd0)), 32'd0);
      end
      if (req_ready) check("idle_quiet", 32'({mem_r, mem_w}), 32'd0);
      if (b_done) b_done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, w;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    b_req_valid = 1'b0; b_req_addr = 32'd0;
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      a = (i >= 16) ? 32'hFFFFFFC0 + 32'((i - 16) * 4) : 32'(i * 4);
      init_img[i] = w;
      for (int b = 0; b < 4; b++) mb[a + 32'(b)] = w[8*b +: 8];
    end

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_mem_rw", 32'({mem_r, mem_w}), 32'd0);
    check("rst_mem_in", mem_in, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    // Reset during the store beat: no write, no done, ready straight away
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("midrst_mem_w", 32'(mem_w), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    check("midrst_word", ram[8], init_img[8]);
    last_rdata = 32'd0;

    // Aligned word store and load
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("sw_mem_w", 32'(mem_w), 32'hF);
    check("sw_mem_in", mem_in, 32'hDEADBEEF);
    check("sw_mem_addr", mem_addr, 32'h10);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1);

    // Byte store to lane 3, then signed and unsigned byte loads
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h12345680, 1'b1);
    @(negedge clk);
    check("sb_mem_w", 32'(mem_w), 32'b1000);
    check("sb_mem_in", 32'(mem_in[31:24]), 32'h80);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 1'b1);

    // Halfword straddling 0x17/0x18
    issue(1'b1, 2'd1, 1'b0, 32'h17, 32'h0000A1B2, 1'b1);
    @(negedge clk);
    check("sh_b0_addr", mem_addr, 32'h14);
    check("sh_b0_w", 32'(mem_w), 32'b1000);
    check("sh_b0_byte", 32'(mem_in[31:24]), 32'hB2);
    @(negedge clk);
    check("sh_b1_addr", mem_addr, 32'h18);
    check("sh_b1_w", 32'(mem_w), 32'b0001);
    check("sh_b1_byte", 32'(mem_in[7:0]), 32'hA1);
    issue(1'b0, 2'd1, 1'b0, 32'h17, 32'd0, 1'b1);

    // Word load wrapping from the top of the address space
    issue(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'd0, 1'b1);
    @(negedge clk);
    check("wrap_b0_addr", mem_addr, 32'hFFFFFFFC);
    check("wrap_b0_r", 32'(mem_r), 32'd1);
    @(negedge clk);
    check("wrap_b1_addr", mem_addr, 32'h0);
    check("wrap_b1_r", 32'(mem_r), 32'd1);

    for (int k = 0; k < 300; k++) begin
      a = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFC0 + 32'($urandom_range(0, 63))
                                      : 32'($urandom_range(0, 59));
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'b1);
    end

    for (int g = 0; g < 100 && sbq.size() != 0; g++) @(negedge clk);
    check("drain", 32'(sbq.size()), 32'd0);

    // Instance with misaligned accesses rejected
    @(negedge clk);
    check("b_ready", 32'(b_req_ready), 32'd1);
    b_req_addr = 32'h20; b_req_valid = 1'b1;
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    @(negedge clk);
    check("b_acc_r", 32'(b_mem_r), 32'd1);
    check("b_acc_addr", b_mem_addr, 32'h20);
    check("b_acc_w", 32'(b_mem_w), 32'd0);
    @(negedge clk);
    check("b_lw_done", 32'({b_done, b_err}), 32'b10);
    check("b_lw_rdata", b_rdata, 32'h5A5A5A5A);
    @(negedge clk);
    b_req_addr = 32'h21; b_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b_rej_rw", 32'({b_mem_r, b_mem_w}), 32'd0);
    check("b_rej_done_err", 32'({b_done, b_err}), 32'b11);
    check("b_rej_rdata", b_rdata, 32'd0);
    check("b_rej_ready", 32'(b_req_ready), 32'd0);
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("b_done_count", 32'(b_done_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
